jtpang_dma_arb: RTL and testbench

JTPANG_DMA_ARB -- requirements
Module: jtpang_dma_arb

---
 rtl/jtpang_pkg.sv | 5 +
 rtl/jtpang_dma_arb_if.sv | 22 ++
 rtl/jtpang_dma_arb.sv | 82 ++++++++
 tb/tb_jtpang_dma_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_pkg.sv
// jtpang_pkg: shared FSM state type and default object-table base for the jtpang DMA arbiter.
package jtpang_pkg;
    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} dma_state_t;
    localparam logic [3:0] DMA_BASE = 4'hC;
endpackage

// File: rtl/jtpang_dma_arb_if.sv
// jtpang_dma_arb_if: Z80 bus handshake, object-engine DMA and CPU work-RAM signals of the arbiter.
interface jtpang_dma_arb_if;
    logic       dma_trig;
    logic       cpu_busrq_n;
    logic       cpu_busak_n;
    logic       dma_go;
    logic       busrq;
    logic       busak_n;
    logic [8:0] dma_addr;
    logic [7:0] dma_din;
    logic [12:0] ram_addr;
    logic       ram_cs;
    logic [7:0] ram_dout;
    modport master(
        input  dma_trig, cpu_busak_n, busrq, dma_addr, ram_dout,
        output cpu_busrq_n, dma_go, busak_n, dma_din, ram_addr, ram_cs
    );
    modport slave(
        output dma_trig, cpu_busak_n, busrq, dma_addr, ram_dout,
        input  cpu_busrq_n, dma_go, busak_n, dma_din, ram_addr, ram_cs
    );
endinterface

// File: rtl/jtpang_dma_arb.sv
// jtpang_dma_arb: hands the Z80 work RAM to the object engine for DMA of the object table.
// Define JTPANG_DMA_TIMEOUT_EN to bound each grant to TIMEOUT clk cycles.
module jtpang_dma_arb
    import jtpang_pkg::*;
#(
    parameter logic [3:0]  BASE    = DMA_BASE,
    parameter logic [15:0] TIMEOUT = 16'd16384
) (
    input logic              clk,
    input logic              rst,
    jtpang_dma_arb_if.master bus
);
    dma_state_t state_q, state_d;
    logic       trig_q;
    logic [1:0] go_q, go_d;
    logic [7:0] din_q, din_d;
    logic       grant, tmo, can_req;

`ifdef JTPANG_DMA_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        blk_q, blk_d;
    assign tmo     = grant && cnt_q == TIMEOUT - 16'd1;
    assign can_req = !blk_q;
    // The counter rests at zero outside GRANT, so every grant starts from zero.
    assign cnt_d   = grant ? cnt_q + 16'd1 : '0;
    // A timed-out requester must drop busrq before it may request again.
    assign blk_d   = tmo ? 1'b1 : (bus.busrq ? blk_q : 1'b0);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            blk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo     = 1'b0;
    assign can_req = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.busrq && can_req) state_d = REQ;
            REQ:     if (!bus.busrq) state_d = RELEASE;
                     else if (!bus.cpu_busak_n) state_d = GRANT;
            GRANT:   if (!bus.busrq || tmo) state_d = RELEASE;
            RELEASE: if (bus.cpu_busak_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant = state_q == GRANT;
    // dma_go is a two-cycle pulse launched only by a trigger edge seen in IDLE.
    assign go_d  = (state_q == IDLE && bus.dma_trig && !trig_q && go_q == 2'd0) ? 2'd2
                 : go_q - {1'b0, |go_q};
    assign din_d = grant ? bus.ram_dout : din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            go_q    <= 2'd0;
            din_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            trig_q  <= bus.dma_trig;
            go_q    <= go_d;
            din_q   <= din_d;
        end
    end

    assign bus.cpu_busrq_n = !(state_q == REQ || grant);
    assign bus.busak_n     = !grant;
    assign bus.ram_cs      = grant;
    assign bus.ram_addr    = {BASE, bus.dma_addr};
    assign bus.dma_go      = |go_q;
    assign bus.dma_din     = din_q;
endmodule

// File: tb/tb_jtpang_dma_arb.sv
// tb_jtpang_dma_arb: self-checking bench for the jtpang DMA arbiter with a synchronous work-RAM model.
module tb_jtpang_dma_arb;
`ifdef JTPANG_DMA_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd100;
`else
    localparam logic [15:0] TO = 16'd16384;
`endif
    localparam logic [3:0] BASE = 4'hC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] mem [8192];

    jtpang_dma_arb_if bus();
    jtpang_dma_arb #(.BASE(BASE), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dma_trig = 1'b0;
        bus.cpu_busak_n = 1'b1;
        bus.busrq = 1'b0;
        bus.dma_addr = '0;
        step();
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n, bus.dma_go, bus.ram_cs} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 1100", {bus.cpu_busrq_n, bus.busak_n, bus.dma_go, bus.ram_cs});
        end
        tests++;
        if (bus.dma_din !== 8'h00) begin
            fails++;
            $display("FAIL reset_din: got %h want 00", bus.dma_din);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_trig();
        logic [7:0] seen;
        int hold;
        hold = $urandom_range(1, 5);
        bus.dma_trig = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            seen[i] = bus.dma_go;
            if (i == hold - 1) bus.dma_trig = 1'b0;
        end
        tests++;
        if (seen !== 8'b0000_0011) begin
            fails++;
            $display("FAIL trig_pulse: got %b want 00000011 (hold %0d)", seen, hold);
        end
    endtask

    task automatic test_idle_ack();
        logic ok;
        ok = 1'b1;
        bus.cpu_busak_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if ({bus.cpu_busrq_n, bus.busak_n, bus.ram_cs} !== 3'b110) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL idle_ack: got %b want 110", {bus.cpu_busrq_n, bus.busak_n, bus.ram_cs});
        end
        bus.cpu_busak_n = 1'b1;
        step();
    endtask

    task automatic test_grant(input int wait_n);
        logic       ok;
        logic [8:0] a, prev;
        bus.busrq = 1'b1;
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n} !== 2'b01) begin
            fails++;
            $display("FAIL req_entry: got %b want 01", {bus.cpu_busrq_n, bus.busak_n});
        end
        ok = 1'b1;
        for (int i = 0; i < wait_n; i++) begin
            step();
            if ({bus.cpu_busrq_n, bus.busak_n} !== 2'b01) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL req_hold: got %b want 01 over %0d cycles", {bus.cpu_busrq_n, bus.busak_n}, wait_n);
        end
        bus.cpu_busak_n = 1'b0;
        step();
        tests++;
        if ({bus.busak_n, bus.ram_cs} !== 2'b01) begin
            fails++;
            $display("FAIL grant_entry: got %b want 01", {bus.busak_n, bus.ram_cs});
        end
        bus.dma_addr = 9'd3;
        #1;
        tests++;
        if (bus.ram_addr !== 13'h1803) begin
            fails++;
            $display("FAIL ram_addr_fixed: got %h want 1803", bus.ram_addr);
        end
        step();
        step();
        tests++;
        if (bus.dma_din !== 8'hA5) begin
            fails++;
            $display("FAIL din_fixed: got %h want a5", bus.dma_din);
        end
        prev = 9'd3;
        for (int i = 0; i < 12; i++) begin
            a = 9'($urandom);
            bus.dma_addr = a;
            #1;
            tests++;
            if (bus.ram_addr !== {BASE, a}) begin
                fails++;
                $display("FAIL ram_addr_rand: got %h want %h", bus.ram_addr, {BASE, a});
            end
            step();
            tests++;
            if (bus.dma_din !== mem[{BASE, prev}]) begin
                fails++;
                $display("FAIL din_rand: got %h want %h (addr %h)", bus.dma_din, mem[{BASE, prev}], prev);
            end
            prev = a;
        end
        ok = 1'b1;
        bus.dma_trig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.dma_go !== 1'b0 || bus.busak_n !== 1'b0) ok = 1'b0;
        end
        bus.dma_trig = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL trig_in_grant: got go=%b busak_n=%b want 0 0", bus.dma_go, bus.busak_n);
        end
    endtask

    task automatic test_release();
        logic       ok;
        logic [7:0] last;
        int         n;
        bus.busrq = 1'b0;
        bus.dma_addr = 9'($urandom);
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n, bus.ram_cs} !== 3'b110) begin
            fails++;
            $display("FAIL release_entry: got %b want 110", {bus.cpu_busrq_n, bus.busak_n, bus.ram_cs});
        end
        last = bus.dma_din;
        bus.busrq = 1'b1;
        n = $urandom_range(1, 4);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.dma_addr = 9'($urandom);
            step();
            if ({bus.cpu_busrq_n, bus.busak_n} !== 2'b11) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL release_hold: got %b want 11", {bus.cpu_busrq_n, bus.busak_n});
        end
        tests++;
        if (bus.dma_din !== last) begin
            fails++;
            $display("FAIL din_hold: got %h want %h", bus.dma_din, last);
        end
        bus.cpu_busak_n = 1'b1;
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.dma_go} !== 2'b10) begin
            fails++;
            $display("FAIL release_to_idle: got %b want 10", {bus.cpu_busrq_n, bus.dma_go});
        end
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n, bus.dma_go} !== 3'b010) begin
            fails++;
            $display("FAIL idle_to_req: got %b want 010", {bus.cpu_busrq_n, bus.busak_n, bus.dma_go});
        end
        bus.busrq = 1'b0;
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n} !== 2'b11) begin
            fails++;
            $display("FAIL req_abandon: got %b want 11", {bus.cpu_busrq_n, bus.busak_n});
        end
        step();
    endtask

    task automatic test_rst_grant();
        mem[{BASE, 9'h1F0}] = 8'h5A;
        bus.busrq = 1'b1;
        bus.cpu_busak_n = 1'b0;
        bus.dma_addr = 9'h1F0;
        step();
        step();
        step();
        step();
        tests++;
        if ({bus.busak_n, bus.dma_din} !== {1'b0, 8'h5A}) begin
            fails++;
            $display("FAIL pre_rst_grant: got busak_n=%b din=%h want 0 5a", bus.busak_n, bus.dma_din);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n, bus.dma_go, bus.ram_cs, bus.dma_din} !== {4'b1100, 8'h00}) begin
            fails++;
            $display("FAIL rst_in_grant: got %b want 110000000000",
                     {bus.cpu_busrq_n, bus.busak_n, bus.dma_go, bus.ram_cs, bus.dma_din});
        end
        step();
        tests++;
        if ({bus.cpu_busrq_n, bus.busak_n} !== 2'b01) begin
            fails++;
            $display("FAIL rst_then_req: got %b want 01", {bus.cpu_busrq_n, bus.busak_n});
        end
        step();
        tests++;
        if (bus.busak_n !== 1'b0) begin
            fails++;
            $display("FAIL rst_then_grant: got %b want 0", bus.busak_n);
        end
        bus.busrq = 1'b0;
        step();
        bus.cpu_busak_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_timeout();
        int n;
        bus.busrq = 1'b1;
        bus.cpu_busak_n = 1'b0;
        step();
        step();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.busak_n === 1'b0) n++;
            step();
        end
`ifdef JTPANG_DMA_TIMEOUT_EN
        begin
            logic ok;
            tests++;
            if (n != 100) begin
                fails++;
                $display("FAIL timeout_len: got %0d grant cycles want 100", n);
            end
            bus.cpu_busak_n = 1'b1;
            ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step();
                if (bus.cpu_busrq_n !== 1'b1) ok = 1'b0;
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL timeout_block: got cpu_busrq_n=%b want 1", bus.cpu_busrq_n);
            end
            bus.busrq = 1'b0;
            step();
            bus.busrq = 1'b1;
            step();
            tests++;
            if (bus.cpu_busrq_n !== 1'b0) begin
                fails++;
                $display("FAIL timeout_rearm: got %b want 0", bus.cpu_busrq_n);
            end
            bus.busrq = 1'b0;
            step();
            step();
        end
`else
        tests++;
        if (n != 200) begin
            fails++;
            $display("FAIL no_timeout: got %0d grant cycles want 200", n);
        end
        bus.busrq = 1'b0;
        step();
        tests++;
        if (bus.busak_n !== 1'b1) begin
            fails++;
            $display("FAIL no_timeout_release: got %b want 1", bus.busak_n);
        end
        bus.cpu_busak_n = 1'b1;
        step();
        step();
`endif
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        mem[13'h1803] = 8'hA5;
        test_reset();
        test_trig();
        test_idle_ack();
        test_grant(5);
        test_release();
        test_grant($urandom_range(1, 8));
        test_release();
        test_rst_grant();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
